// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit.
package mem_lsu_pkg;

    // Load type codes
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;

    // Store type codes
    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // Access size check; a load takes priority when both qualifiers are set.
    function automatic logic is_misaligned(input logic [2:0] ld, input logic [1:0] st,
                                           input logic [1:0] off);
        logic half, word;
        if (ld != LD_NONE) begin
            half = (ld == LD_LH) || (ld == LD_LHU);
            word = (ld == LD_LW);
        end else begin
            half = (st == ST_SH);
            word = (st == ST_SW);
        end
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load data lane extraction and sign/zero extension.
module lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] rsp_data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_type,
    output logic [31:0] data
);

    logic [31:0] lane;

    // Shift the addressed byte lane down, then extend per load type.
    always_comb begin
        lane = rsp_data >> {addr_lo, 3'b000};
        data = rsp_data;
        case (ld_type)
            LD_LB:   data = {{24{lane[7]}}, lane[7:0]};
            LD_LH:   data = {{16{lane[15]}}, lane[15:0]};
            LD_LBU:  data = {24'd0, lane[7:0]};
            LD_LHU:  data = {16'd0, lane[15:0]};
            default: data = rsp_data;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one dcache request per memory op,
// one registered writeback record per accepted instruction.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_WIDTH-1:0] EX_AluData,
    input  logic [DATA_WIDTH-1:0] ex_st_data,
    input  logic [2:0]            ex_ld_type,
    input  logic [1:0]            ex_st_type,
    input  logic [4:0]            ex_rd,
    output logic                  dc_req_valid,
    input  logic                  dc_req_ready,
    output logic [ADDR_WIDTH-1:0] dc_req_addr,
    output logic                  dc_req_we,
    output logic [3:0]            dc_req_wstrb,
    output logic [DATA_WIDTH-1:0] dc_req_wdata,
    input  logic                  dc_rsp_valid,
    input  logic [DATA_WIDTH-1:0] dc_rsp_data,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_misalign
);

    logic [1:0]            state;
    logic [1:0]            r_off;
    logic [2:0]            r_ld;
    logic [4:0]            r_rd;
    logic [DATA_WIDTH-1:0] ld_data;

    logic                  is_ld, is_st, mis;
    logic [1:0]            off;
    logic [3:0]            st_strb;
    logic [DATA_WIDTH-1:0] st_wdata;

    assign ex_ready = (state == S_IDLE);

    // Decode the incoming op and pre-format store strobes/data.
    always_comb begin
        off      = EX_AluData[1:0];
        is_ld    = (ex_ld_type != LD_NONE);
        is_st    = !is_ld && (ex_st_type != ST_NONE);
        mis      = is_misaligned(ex_ld_type, ex_st_type, off);
        st_strb  = 4'b0000;
        st_wdata = '0;
        if (is_st) begin
            case (ex_st_type)
                ST_SB: begin
                    st_strb  = 4'(4'b0001 << off);
                    st_wdata = {4{ex_st_data[7:0]}};
                end
                ST_SH: begin
                    st_strb  = 4'(4'b0011 << {off[1], 1'b0});
                    st_wdata = {2{ex_st_data[15:0]}};
                end
                default: begin
                    st_strb  = 4'b1111;
                    st_wdata = ex_st_data;
                end
            endcase
        end
    end

    lsu_load_align u_align (
        .rsp_data (dc_rsp_data),
        .addr_lo  (r_off),
        .ld_type  (r_ld),
        .data     (ld_data)
    );

    // Control FSM plus registered request and writeback record.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            r_off        <= 2'b00;
            r_ld         <= LD_NONE;
            r_rd         <= 5'd0;
            dc_req_valid <= 1'b0;
            dc_req_addr  <= '0;
            dc_req_we    <= 1'b0;
            dc_req_wstrb <= 4'b0000;
            dc_req_wdata <= '0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= '0;
            wb_misalign  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (!is_ld && !is_st) begin
                            wb_valid    <= 1'b1;
                            wb_we       <= (ex_rd != 5'd0);
                            wb_rd       <= ex_rd;
                            wb_data     <= EX_AluData;
                            wb_misalign <= 1'b0;
                        end else if (mis) begin
                            // Faulting address goes out as the record's data.
                            wb_valid    <= 1'b1;
                            wb_we       <= 1'b0;
                            wb_rd       <= ex_rd;
                            wb_data     <= EX_AluData;
                            wb_misalign <= 1'b1;
                        end else begin
                            r_off        <= off;
                            r_ld         <= ex_ld_type;
                            r_rd         <= ex_rd;
                            dc_req_valid <= 1'b1;
                            dc_req_addr  <= {EX_AluData[ADDR_WIDTH-1:2], 2'b00};
                            dc_req_we    <= is_st;
                            dc_req_wstrb <= st_strb;
                            dc_req_wdata <= st_wdata;
                            state        <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dc_req_ready) begin
                        dc_req_valid <= 1'b0;
                        if (dc_req_we) begin
                            wb_valid    <= 1'b1;
                            wb_we       <= 1'b0;
                            wb_rd       <= r_rd;
                            wb_data     <= dc_req_addr;
                            wb_misalign <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dc_rsp_valid) begin
                        wb_valid    <= 1'b1;
                        wb_we       <= (r_rd != 5'd0);
                        wb_rd       <= r_rd;
                        wb_data     <= ld_data;
                        wb_misalign <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed table-driven bench for mem_lsu plus multi-cycle corner sequences.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [31:0] EX_AluData, ex_st_data;
    logic [2:0]  ex_ld_type;
    logic [1:0]  ex_st_type;
    logic [4:0]  ex_rd;
    logic        dc_req_valid, dc_req_ready, dc_req_we;
    logic [31:0] dc_req_addr, dc_req_wdata;
    logic [3:0]  dc_req_wstrb;
    logic        dc_rsp_valid;
    logic [31:0] dc_rsp_data;
    logic        wb_valid, wb_we, wb_misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .EX_AluData(EX_AluData), .ex_st_data(ex_st_data),
        .ex_ld_type(ex_ld_type), .ex_st_type(ex_st_type), .ex_rd(ex_rd),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_we(dc_req_we),
        .dc_req_wstrb(dc_req_wstrb), .dc_req_wdata(dc_req_wdata),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_misalign(wb_misalign)
    );

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;

    always @(posedge clk) if (dc_req_valid && dc_req_ready) hs_cnt <= hs_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // kind: 0 non-memory, 1 misaligned, 2 store, 3 load
    typedef struct {
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [31:0] rsp;
        int          kind;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] ld, input logic [1:0] st,
                                input logic [31:0] alu, input logic [31:0] sd,
                                input logic [4:0] rd, input logic [31:0] rsp, input int kind,
                                input logic [31:0] e_addr, input logic [3:0] e_strb,
                                input logic [31:0] e_wdata, input logic e_we,
                                input logic [31:0] e_data);
        vec_t v;
        v.ld = ld; v.st = st; v.alu = alu; v.sd = sd; v.rd = rd; v.rsp = rsp;
        v.kind = kind; v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata;
        v.e_we = e_we; v.e_data = e_data;
        return v;
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; EX_AluData = 0; ex_st_data = 0; ex_ld_type = 0; ex_st_type = 0;
        ex_rd = 0; dc_req_ready = 0; dc_rsp_valid = 0; dc_rsp_data = 0;
    endtask

    task automatic drive_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] alu,
                            input logic [31:0] sd, input logic [4:0] rd);
        ex_valid = 1; ex_ld_type = ld; ex_st_type = st; EX_AluData = alu;
        ex_st_data = sd; ex_rd = rd;
    endtask

    vec_t vt[13];

    initial begin
        vt[0]  = mk(3'd0, 2'd0, 32'h1234,     32'h0,        5'd5,  32'h0,        0, 0, 0, 0, 1'b1, 32'h1234);
        vt[1]  = mk(3'd0, 2'd0, 32'hDEAD,     32'h0,        5'd0,  32'h0,        0, 0, 0, 0, 1'b0, 32'hDEAD);
        vt[2]  = mk(3'd0, 2'd1, 32'h103,      32'hAB,       5'd1,  32'h0,        2, 32'h100, 4'b1000, 32'hABABABAB, 1'b0, 0);
        vt[3]  = mk(3'd0, 2'd2, 32'h102,      32'h1234BEEF, 5'd2,  32'h0,        2, 32'h100, 4'b1100, 32'hBEEFBEEF, 1'b0, 0);
        vt[4]  = mk(3'd0, 2'd3, 32'h204,      32'hCAFEF00D, 5'd3,  32'h0,        2, 32'h204, 4'b1111, 32'hCAFEF00D, 1'b0, 0);
        vt[5]  = mk(3'd1, 2'd0, 32'h102,      32'h0,        5'd7,  32'h00800000, 3, 32'h100, 0, 0, 1'b1, 32'hFFFFFF80);
        vt[6]  = mk(3'd5, 2'd0, 32'h102,      32'h0,        5'd8,  32'h80010000, 3, 32'h100, 0, 0, 1'b1, 32'h00008001);
        vt[7]  = mk(3'd2, 2'd0, 32'h100,      32'h0,        5'd9,  32'h12348765, 3, 32'h100, 0, 0, 1'b1, 32'hFFFF8765);
        vt[8]  = mk(3'd4, 2'd0, 32'h101,      32'h0,        5'd10, 32'h0000F200, 3, 32'h100, 0, 0, 1'b1, 32'h000000F2);
        vt[9]  = mk(3'd3, 2'd0, 32'h300,      32'h0,        5'd0,  32'h89ABCDEF, 3, 32'h300, 0, 0, 1'b0, 32'h89ABCDEF);
        vt[10] = mk(3'd3, 2'd0, 32'h101,      32'h0,        5'd4,  32'h0,        1, 0, 0, 0, 1'b0, 0);
        vt[11] = mk(3'd0, 2'd2, 32'h201,      32'h5555,     5'd6,  32'h0,        1, 0, 0, 0, 1'b0, 0);
        // both qualifiers set: the aligned LB wins over the misaligned SW
        vt[12] = mk(3'd1, 2'd3, 32'h101,      32'hFFFFFFFF, 5'd3,  32'h00005A00, 3, 32'h100, 0, 0, 1'b1, 32'h0000005A);

        idle_inputs();
        rst = 1;
        @(negedge clk);
        chk("rst_ex_ready", 32'(ex_ready), 1);
        @(negedge clk);
        rst = 0;
        chk("rst_req_valid", 32'(dc_req_valid), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_we", 32'(wb_we), 0);
        chk("rst_wb_mis", 32'(wb_misalign), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_req_addr", dc_req_addr, 0);
        chk("rst_req_strb", 32'(dc_req_wstrb), 0);
        chk("rst_req_wdata", dc_req_wdata, 0);
        chk("rst_req_we", 32'(dc_req_we), 0);

        // Table: every op completes with zero-stall ready and next-cycle response.
        for (int i = 0; i < 13; i++) begin
            drive_op(vt[i].ld, vt[i].st, vt[i].alu, vt[i].sd, vt[i].rd);
            chk($sformatf("v%0d_ex_ready", i), 32'(ex_ready), 1);
            @(negedge clk);
            ex_valid = 0;
            if (vt[i].kind >= 2) begin
                chk($sformatf("v%0d_req_valid", i), 32'(dc_req_valid), 1);
                chk($sformatf("v%0d_req_addr", i), dc_req_addr, vt[i].e_addr);
                chk($sformatf("v%0d_req_we", i), 32'(dc_req_we), (vt[i].kind == 2) ? 1 : 0);
                chk($sformatf("v%0d_ex_ready_busy", i), 32'(ex_ready), 0);
                chk($sformatf("v%0d_early_wb", i), 32'(wb_valid), 0);
                if (vt[i].kind == 2) begin
                    chk($sformatf("v%0d_req_strb", i), 32'(dc_req_wstrb), 32'(vt[i].e_strb));
                    chk($sformatf("v%0d_req_wdata", i), dc_req_wdata, vt[i].e_wdata);
                end
                dc_req_ready = 1;
                @(negedge clk);
                dc_req_ready = 0;
                if (vt[i].kind == 3) begin
                    chk($sformatf("v%0d_req_dropped", i), 32'(dc_req_valid), 0);
                    dc_rsp_valid = 1; dc_rsp_data = vt[i].rsp;
                    @(negedge clk);
                    dc_rsp_valid = 0; dc_rsp_data = 0;
                end
            end else begin
                chk($sformatf("v%0d_no_req", i), 32'(dc_req_valid), 0);
            end
            chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 1);
            chk($sformatf("v%0d_wb_we", i), 32'(wb_we), 32'(vt[i].e_we));
            chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vt[i].rd));
            chk($sformatf("v%0d_wb_mis", i), 32'(wb_misalign), (vt[i].kind == 1) ? 1 : 0);
            if (vt[i].kind == 0 || vt[i].kind == 3)
                chk($sformatf("v%0d_wb_data", i), wb_data, vt[i].e_data);
            chk($sformatf("v%0d_ready_after", i), 32'(ex_ready), 1);
            @(negedge clk);
            chk($sformatf("v%0d_wb_pulse", i), 32'(wb_valid), 0);
        end

        // Back-to-back non-memory ops, one writeback per cycle.
        drive_op(3'd0, 2'd0, 32'hA1, 0, 5'd11);
        @(negedge clk);
        chk("b2b_ready", 32'(ex_ready), 1);
        drive_op(3'd0, 2'd0, 32'hB2, 0, 5'd12);
        chk("b2b0_valid", 32'(wb_valid), 1);
        chk("b2b0_data", wb_data, 32'hA1);
        @(negedge clk);
        ex_valid = 0;
        chk("b2b1_valid", 32'(wb_valid), 1);
        chk("b2b1_data", wb_data, 32'hB2);
        chk("b2b1_rd", 32'(wb_rd), 12);
        @(negedge clk);

        // Backpressure: ready low for 3 cycles, request must hold steady.
        begin
            int hs0;
            hs0 = hs_cnt;
            drive_op(3'd0, 2'd3, 32'h40, 32'h11223344, 5'd13);
            @(negedge clk);
            ex_valid = 0; EX_AluData = 32'hFFFF_FFFF; ex_st_data = 0;
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("bp%0d_valid", c), 32'(dc_req_valid), 1);
                chk($sformatf("bp%0d_addr", c), dc_req_addr, 32'h40);
                chk($sformatf("bp%0d_strb", c), 32'(dc_req_wstrb), 32'hF);
                chk($sformatf("bp%0d_wdata", c), dc_req_wdata, 32'h11223344);
                chk($sformatf("bp%0d_we", c), 32'(dc_req_we), 1);
                chk($sformatf("bp%0d_ex_ready", c), 32'(ex_ready), 0);
                chk($sformatf("bp%0d_wb", c), 32'(wb_valid), 0);
                @(negedge clk);
            end
            chk("bp_valid_last", 32'(dc_req_valid), 1);
            dc_req_ready = 1;
            @(negedge clk);
            dc_req_ready = 0;
            chk("bp_wb_valid", 32'(wb_valid), 1);
            chk("bp_wb_we", 32'(wb_we), 0);
            chk("bp_req_done", 32'(dc_req_valid), 0);
            @(negedge clk);
            chk("bp_handshakes", 32'(hs_cnt - hs0), 1);
        end

        // Response stall: LH at 0x82, response two cycles late.
        drive_op(3'd2, 2'd0, 32'h82, 0, 5'd14);
        @(negedge clk);
        ex_valid = 0;
        dc_req_ready = 1;
        @(negedge clk);
        dc_req_ready = 0;
        dc_rsp_valid = 0;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("rs%0d_wb", c), 32'(wb_valid), 0);
            chk($sformatf("rs%0d_ex_ready", c), 32'(ex_ready), 0);
            @(negedge clk);
        end
        dc_rsp_valid = 1; dc_rsp_data = 32'h7FFE0000;
        @(negedge clk);
        dc_rsp_valid = 0;
        chk("rs_wb_valid", 32'(wb_valid), 1);
        chk("rs_wb_data", wb_data, 32'h00007FFE);
        @(negedge clk);

        // Reset while waiting; late response in IDLE must be ignored.
        drive_op(3'd3, 2'd0, 32'h80, 0, 5'd15);
        @(negedge clk);
        ex_valid = 0;
        dc_req_ready = 1;
        @(negedge clk);
        dc_req_ready = 0;
        chk("rw_in_wait", 32'(ex_ready), 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        dc_rsp_valid = 1; dc_rsp_data = 32'hDEADBEEF;
        @(negedge clk);
        dc_rsp_valid = 0;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("rw%0d_wb", c), 32'(wb_valid), 0);
            chk($sformatf("rw%0d_data", c), wb_data, 0);
            chk($sformatf("rw%0d_we", c), 32'(wb_we), 0);
            chk($sformatf("rw%0d_rd", c), 32'(wb_rd), 0);
            chk($sformatf("rw%0d_req", c), 32'(dc_req_valid), 0);
            chk($sformatf("rw%0d_ready", c), 32'(ex_ready), 1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit that sits directly downstream of the execute stage. It consumes the execute stage's result, address and load/store qualifiers. For loads and stores it issues a single request to the data cache over a valid/ready handshake, waits for the response and aligns and extends load data. It presents one registered writeback record per accepted instruction and stalls execute via `ex_ready` while a memory access is outstanding.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data width; fixed at 32 for RV32.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
- `ex_valid`  in  1  execute result valid this cycle.
- `ex_ready`  out  1  unit accepts the execute result this cycle.
- `EX_AluData`  in  DATA_WIDTH  ALU result; the effective address when a load or store is requested.
- `ex_st_data`  in  DATA_WIDTH  store source (forwarded rs2).
- `ex_ld_type`  in  3  load type code, package encoding.
- `ex_st_type`  in  2  store type code, package encoding.
- `ex_rd`  in  5  destination register.
- `dc_req_valid`  out  1  dcache request valid.
- `dc_req_ready`  in  1  dcache accepts the request.
- `dc_req_addr`  out  ADDR_WIDTH  word-aligned address (`[1:0]`=0).
- `dc_req_we`  out  1  1=store, 0=load.
- `dc_req_wstrb`  out  4  byte strobes.
- `dc_req_wdata`  out  DATA_WIDTH  lane-replicated store data.
- `dc_rsp_valid`  in  1  load response valid.
- `dc_rsp_data`  in  DATA_WIDTH  aligned word read.
- `wb_valid`  out  1  writeback record valid, one-cycle pulse.
- `wb_we`  out  1  register file write enable.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  DATA_WIDTH  writeback value.
- `wb_misalign`  out  1  misaligned access exception.

## Operation
- FSM states: IDLE, REQ, WAIT. `ex_ready` = (state==IDLE).
- IDLE with `ex_valid`:
  - Non-memory op (ld_type=NONE, st_type=NONE): register `wb_*` with `wb_we`=(rd!=0) and `wb_data`=EX_AluData; stay in IDLE.
  - Misaligned access: issue no dcache request. Emit `wb_valid`=1, `wb_misalign`=1, `wb_we`=0. Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Aligned load or store: latch addr, type, rd and data; go to REQ.
- Both ld_type and st_type nonzero is illegal; load takes priority.
- REQ: `dc_req_valid`=1 and all request fields stay stable until `dc_req_ready`.
  - On handshake, a store emits a writeback record (`wb_we`=0) next cycle and the FSM returns to IDLE.
  - On handshake, a load goes to WAIT.
- WAIT: on `dc_rsp_valid`, extract and extend the addressed lane, register `wb_*` with `wb_we`=(rd!=0), and return to IDLE.
- Store formatting:
  - SB: wstrb=`4'b0001<<addr[1:0]`; wdata is the low byte replicated ×4.
  - SH: wstrb=`4'b0011<<{addr[1],1'b0}`; wdata is the low half replicated ×2.
  - SW: wstrb=`4'b1111`.
- Load extraction: lane = `dc_rsp_data>>(8*addr[1:0])`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `dc_rsp_valid` outside WAIT is ignored.
- A dcache response arrives no earlier than the cycle after the request handshake.

## Timing
- Reset values: state=IDLE, `dc_req_valid`=0, `wb_valid`=0, `wb_we`=0, `wb_misalign`=0, `wb_rd`=0, `wb_data`=0, `dc_req_addr/wstrb/wdata`=0, `dc_req_we`=0. `ex_ready` is 1 during and after reset.
- Non-memory or misaligned op: accepted at cycle N; `wb_valid` at N+1. Back-to-back sustains one per cycle.
- Load: accepted at N; `dc_req_valid` at N+1. With ready at N+1 and response at N+2, `wb_valid` is at N+3. Each ready or response stall adds one cycle.
- Store: accepted at N; request at N+1; `wb_valid` the cycle after the handshake.
- `ex_ready` is 0 from N+1 until the cycle after the transaction completes.
- `rst` mid-transaction: abandon the request or response, return to IDLE, and emit no writeback.

## Structure
- Shared package/defines:
  - LD_TYPE codes: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5.
  - ST_TYPE codes: NONE=0, SB=1, SH=2, SW=3.
  - FSM state encoding.
- One sub-module, `lsu_load_align`: combinational lane extract and extend (rsp_data, addr[1:0], ld_type → data).

## Test plan
- Non-memory: EX_AluData=0x1234, rd=5 -> next cycle wb_valid=1, wb_we=1, wb_data=0x1234; a rd=0 variant gives wb_we=0.
- SB: addr 0x103, st_data 0xAB, ready immediately -> dc_req addr=0x100, wstrb=1000, wdata=0xABABABAB, we=1; wb_valid one cycle later.
- LB: addr 0x102, rsp 0x0080_0000 -> wb_data=0xFFFFFF80. LHU at addr 0x102 with rsp 0x8001_0000 -> wb_data=0x00008001.
- Backpressure: dc_req_ready low 3 cycles -> request held stable, ex_ready=0 throughout, exactly one handshake.
- Misaligned LW at addr 0x101 -> no dc_req_valid; wb_misalign=1, wb_we=0 at N+1.
- rst asserted in WAIT; late dc_rsp_valid arrives in IDLE -> no wb_valid; outputs hold reset values.
